// File: rtl/mmm_pkg.sv
// Shared definitions for the modular exponentiation engine and its multiplier.
package mmm_pkg;

  localparam int unsigned WIDTH_DEF   = 256;
  localparam int unsigned MUL_LAT_DEF = 16;
  localparam int unsigned DIVW_DEF    = 87;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mmm_nlp_256b.sv
// Pipelined modular multiplier: o_res = i_a * i_b mod i_m, fixed latency MUL_LAT (>= 4).
// i_m_b = floor(2^(2*WIDTH) / (i_m << lzc(i_m))), i.e. Barrett constant of the normalised modulus.
module mmm_nlp_256b
  import mmm_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIVW    = DIVW_DEF
) (
  input  logic             i_clk,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  input  logic [WIDTH+2:0] i_m_b,
  output logic [WIDTH-1:0] o_res
);

  localparam int unsigned ND  = (WIDTH + DIVW - 1) / DIVW;
  localparam int unsigned BW  = ND * DIVW;
  localparam int unsigned PPW = WIDTH + DIVW;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned MW  = 2 * WIDTH + 4;
  localparam int unsigned QW  = WIDTH + 2;
  localparam int unsigned SW  = $clog2(WIDTH);

  logic [BW-1:0]    b_pad;
  logic [SW-1:0]    m_msb;
  logic [SW-1:0]    m_shift;
  logic [WIDTH-1:0] m_norm;

  logic [PPW-1:0]   s1_pp [ND];
  logic [WIDTH-1:0] s1_n;
  logic [WIDTH+2:0] s1_mu;
  logic [SW-1:0]    s1_shift;

  logic [PW-1:0]    prod;
  logic [PW-1:0]    s2_t;
  logic [WIDTH-1:0] s2_n;
  logic [WIDTH+2:0] s2_mu;
  logic [SW-1:0]    s2_shift;

  logic [MW-1:0]    qmul;
  logic [QW-1:0]    q;
  logic [QW-1:0]    r_est;
  logic [QW-1:0]    s3_r;
  logic [WIDTH-1:0] s3_n;
  logic [SW-1:0]    s3_shift;

  logic [QW-1:0]    r_fix1;
  logic [QW-1:0]    r_fix2;
  logic [WIDTH-1:0] s4_res;

  assign b_pad = BW'(i_b);

  // Normalise the modulus so its MSB sits at WIDTH-1; the product is shifted by the
  // same amount, so the reduced value is the true remainder shifted up.
  always_comb begin
    m_msb = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (i_m[i]) m_msb = SW'(i);
  end

  assign m_shift = SW'(WIDTH - 1) - m_msb;
  assign m_norm  = i_m << m_shift;

  always_ff @(posedge i_clk) begin
    for (int unsigned d = 0; d < ND; d++)
      s1_pp[d] <= PPW'(i_a) * PPW'(b_pad[d*DIVW +: DIVW]);
    s1_n     <= m_norm;
    s1_mu    <= i_m_b;
    s1_shift <= m_shift;
  end

  always_comb begin
    prod = '0;
    for (int unsigned d = 0; d < ND; d++)
      prod = prod + (PW'(s1_pp[d]) << (d * DIVW));
  end

  always_ff @(posedge i_clk) begin
    s2_t     <= prod << s1_shift;
    s2_n     <= s1_n;
    s2_mu    <= s1_mu;
    s2_shift <= s1_shift;
  end

  // Barrett estimate never exceeds the true quotient, and the remainder it leaves is
  // below 3*n, so it fits in QW bits and two conditional subtracts finish it.
  assign qmul  = MW'(s2_t >> (WIDTH - 1)) * MW'(s2_mu);
  assign q     = QW'(qmul >> (WIDTH + 1));
  assign r_est = QW'(s2_t) - (QW'(s2_n) * q);

  always_ff @(posedge i_clk) begin
    s3_r     <= r_est;
    s3_n     <= s2_n;
    s3_shift <= s2_shift;
  end

  assign r_fix1 = (s3_r >= QW'(s3_n)) ? s3_r - QW'(s3_n) : s3_r;
  assign r_fix2 = (r_fix1 >= QW'(s3_n)) ? r_fix1 - QW'(s3_n) : r_fix1;

  always_ff @(posedge i_clk) begin
    s4_res <= WIDTH'(r_fix2 >> s3_shift);
  end

  generate
    if (MUL_LAT > 4) begin : g_dly
      logic [WIDTH-1:0] dly [MUL_LAT-4];

      always_ff @(posedge i_clk) begin
        dly[0] <= s4_res;
        for (int unsigned i = 1; i < MUL_LAT - 4; i++)
          dly[i] <= dly[i-1];
      end

      assign o_res = dly[MUL_LAT-5];
    end else begin : g_nodly
      assign o_res = s4_res;
    end
  endgenerate

endmodule

// File: rtl/mmm_mod_root.sv
// Sequential modular exponentiation o_res = i_x ^ i_e mod i_p (left-to-right square-and-multiply).
// Optional MMM_MOD_ROOT_LEADZ_EN: start at the exponent's leading one instead of bit WIDTH-1.
module mmm_mod_root
  import mmm_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIVW    = DIVW_DEF,
  parameter int unsigned CNT_W   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_e,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH+2:0] i_m_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_res
);

  localparam int unsigned      WC_W    = $clog2(MUL_LAT + 1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MUL_LAT);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] e_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH+2:0] mb_r;
  logic [CNT_W-1:0] idx;
  logic [WC_W-1:0]  wait_cnt;

  logic             accept;
  logic [CNT_W-1:0] idx_start;
  logic             start_done;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_res;

`ifdef MMM_MOD_ROOT_LEADZ_EN
  always_comb begin
    idx_start = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (i_e[i]) idx_start = CNT_W'(i);
  end

  assign start_done = (i_e == '0);
`else
  assign idx_start  = IDX_TOP;
  assign start_done = 1'b0;
`endif

  assign accept = i_valid & o_ready;
  assign mul_b  = (state == ST_MUL) ? x_r : acc;

  mmm_nlp_256b #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIVW    (DIVW)
  ) u_mul (
    .i_clk (i_clk),
    .i_a   (acc),
    .i_b   (mul_b),
    .i_m   (p_r),
    .i_m_b (mb_r),
    .o_res (mul_res)
  );

  // Results still in the multiplier pipeline after a reset are never captured:
  // capture only happens in SQR/MUL at wait_cnt == MUL_LAT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_res    <= '0;
      acc      <= '0;
      x_r      <= '0;
      e_r      <= '0;
      p_r      <= '0;
      mb_r     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            x_r      <= i_x;
            e_r      <= i_e;
            p_r      <= i_p;
            mb_r     <= i_m_b;
            acc      <= WIDTH'(1);
            idx      <= idx_start;
            wait_cnt <= '0;
            if (start_done) begin
              state   <= ST_DONE;
              o_res   <= WIDTH'(1);
              o_valid <= 1'b1;
              o_ready <= 1'b1;
            end else begin
              state   <= ST_SQR;
              o_ready <= 1'b0;
            end
          end
        end
        ST_SQR, ST_MUL: begin
          if (wait_cnt == WC_LAST) begin
            acc      <= mul_res;
            wait_cnt <= '0;
            if (state == ST_SQR && e_r[idx]) begin
              state <= ST_MUL;
            end else if (idx == '0) begin
              state   <= ST_DONE;
              o_res   <= mul_res;
              o_valid <= 1'b1;
              o_ready <= 1'b1;
            end else begin
              idx   <= idx - IDX_ONE;
              state <= ST_SQR;
            end
          end else begin
            wait_cnt <= wait_cnt + WC_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_mod_root.sv
// Self-checking bench for mmm_mod_root against a right-to-left exponentiation reference.
module tb_mmm_mod_root;

  localparam int unsigned W        = 256;
  localparam int unsigned LAT      = 16;
  localparam int unsigned WAIT_MAX = 10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] x;
  logic [W-1:0] e;
  logic [W-1:0] p;
  logic [W+2:0] mb;
  logic [W-1:0] res;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmm_mod_root #(
    .WIDTH   (W),
    .MUL_LAT (LAT),
    .DIVW    (87)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (x),
    .i_e     (e),
    .i_p     (p),
    .i_m_b   (mb),
    .o_valid (o_valid),
    .o_res   (res)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Barrett constant of the modulus normalised to a set top bit.
  function automatic logic [W+2:0] calc_mb(input logic [W-1:0] pp);
    logic [3*W-1:0] n;
    logic [3*W-1:0] num;
    n = (3*W)'(pp);
    while (n[W-1] == 1'b0) n = n << 1;
    num = (3*W)'(1) << (2 * W);
    return (W+3)'(num / n);
  endfunction

  function automatic logic [W-1:0] model_pow(input logic [W-1:0] xx, input logic [W-1:0] ee,
                                             input logic [W-1:0] pp);
    logic [2*W-1:0] r;
    logic [2*W-1:0] b;
    logic [2*W-1:0] m;
    logic [W-1:0]   k;
    m = (2*W)'(pp);
    r = (2*W)'(1);
    b = (2*W)'(xx) % m;
    k = ee;
    for (int i = 0; i < W; i++) begin
      if (k[0]) r = (r * b) % m;
      b = (b * b) % m;
      k = k >> 1;
    end
    return W'(r);
  endfunction

  function automatic int unsigned exp_lat(input logic [W-1:0] ee);
    int unsigned sq;
`ifdef MMM_MOD_ROOT_LEADZ_EN
    sq = 0;
    for (int i = 0; i < W; i++) if (ee[i]) sq = i + 1;
`else
    sq = W;
`endif
    return 1 + (sq + $countones(ee)) * (LAT + 1);
  endfunction

  // Presents one request for exactly one cycle, then scrambles the inputs.
  task automatic send(input logic [W-1:0] xx, input logic [W-1:0] ee, input logic [W-1:0] pp,
                      output int unsigned t0);
    x = xx; e = ee; p = pp; mb = calc_mb(pp);
    i_valid = 1'b1;
    t0 = cyc;
    tick();
    i_valid = 1'b0;
    x = rand256(); e = rand256(); p = rand256(); mb = '0;
  endtask

  task automatic wait_valid(output logic [W-1:0] r, output int unsigned t_seen, output bit ok);
    ok = 1'b0; r = '0; t_seen = 0;
    for (int unsigned i = 0; i < WAIT_MAX; i++) begin
      if (o_valid === 1'b1) begin
        r = res; t_seen = cyc; ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; x = '0; e = '0; p = '0; mb = '0;
    repeat (3) tick();
    rst = 1'b0;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_tests++;
    if (res !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
  endtask

  task automatic test_basic();
    logic [W-1:0] tx [2];
    logic [W-1:0] te [2];
    logic [W-1:0] tr [2];
    logic [W-1:0] r;
    int unsigned  t0, ts;
    bit           ok;
    tx = '{W'(2), W'(9)};
    te = '{W'(5), W'(9)};
    tr = '{W'(9), W'(2)};
    for (int k = 0; k < 2; k++) begin
      send(tx[k], te[k], W'(23), t0);
      n_tests++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL basic%0d_busy: o_ready got %b want 0", k, o_ready); end
      wait_valid(r, ts, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL basic%0d_timeout: no o_valid within %0d cycles", k, WAIT_MAX);
      end else begin
        if (r !== tr[k]) begin n_fail++; $display("FAIL basic%0d_res: got %h want %h", k, r, tr[k]); end
        n_tests++;
        if (ts - t0 != exp_lat(te[k])) begin
          n_fail++; $display("FAIL basic%0d_lat: got %0d want %0d", k, ts - t0, exp_lat(te[k]));
        end
        tick();
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic%0d_pulse: o_valid got %b want 0", k, o_valid); end
      end
    end
  endtask

  task automatic test_edge();
    logic [W-1:0] tx [3];
    logic [W-1:0] te [3];
    logic [W-1:0] tr [3];
    logic [W-1:0] r;
    int unsigned  t0, ts;
    bit           ok;
    tx = '{W'(7), W'(0), W'(7)};
    te = '{W'(0), W'(5), W'(1)};
    tr = '{W'(1), W'(0), W'(7)};
    for (int k = 0; k < 3; k++) begin
      send(tx[k], te[k], W'(23), t0);
      wait_valid(r, ts, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL edge%0d_timeout: no o_valid within %0d cycles", k, WAIT_MAX);
      end else begin
        if (r !== tr[k]) begin n_fail++; $display("FAIL edge%0d_res: got %h want %h", k, r, tr[k]); end
        n_tests++;
        if (ts - t0 != exp_lat(te[k])) begin
          n_fail++; $display("FAIL edge%0d_lat: got %0d want %0d", k, ts - t0, exp_lat(te[k]));
        end
        n_tests++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL edge%0d_ready: got %b want 1", k, o_ready); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r;
    int unsigned  t0, t1, ts;
    bit           ok;
    x = W'(2); e = W'(5); p = W'(23); mb = calc_mb(W'(23));
    i_valid = 1'b1;
    t0 = cyc;
    tick();
    x = W'(3);
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: o_ready got %b want 0", o_ready); end
    wait_valid(r, ts, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_first_timeout: no o_valid within %0d cycles", WAIT_MAX);
      i_valid = 1'b0;
      return;
    end
    if (r !== W'(9)) begin n_fail++; $display("FAIL b2b_first_res: got %h want 9", r); end
    n_tests++;
    if (ts - t0 != exp_lat(W'(5))) begin
      n_fail++; $display("FAIL b2b_first_lat: got %0d want %0d", ts - t0, exp_lat(W'(5)));
    end
    t1 = cyc;
    tick();
    i_valid = 1'b0;
    n_tests++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept: valid/ready got %b%b want 00", o_valid, o_ready);
    end
    wait_valid(r, ts, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL b2b_second_timeout: no o_valid within %0d cycles", WAIT_MAX);
    end else begin
      if (r !== W'(13)) begin n_fail++; $display("FAIL b2b_second_res: got %h want 13", r); end
      n_tests++;
      if (ts - t1 != exp_lat(W'(5))) begin
        n_fail++; $display("FAIL b2b_second_lat: got %0d want %0d", ts - t1, exp_lat(W'(5)));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r;
    int unsigned  t0, ts, spurious;
    bit           ok;
    send(W'(2), W'(5), W'(23), t0);
    while (cyc < t0 + 40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    n_tests++;
    if (res !== '0) begin n_fail++; $display("FAIL rstmid_res: got %h want 0", res); end
    spurious = 0;
    for (int i = 0; i < 120; i++) begin
      if (o_valid !== 1'b0) spurious++;
      tick();
    end
    n_tests++;
    if (spurious != 0) begin n_fail++; $display("FAIL rstmid_spurious: got %0d o_valid cycles want 0", spurious); end
    send(W'(2), W'(5), W'(23), t0);
    wait_valid(r, ts, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL rstmid_fresh_timeout: no o_valid within %0d cycles", WAIT_MAX);
    end else begin
      if (r !== W'(9)) begin n_fail++; $display("FAIL rstmid_fresh_res: got %h want 9", r); end
      n_tests++;
      if (ts - t0 != exp_lat(W'(5))) begin
        n_fail++; $display("FAIL rstmid_fresh_lat: got %0d want %0d", ts - t0, exp_lat(W'(5)));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   pp, xx, ee, want, r;
    logic [2*W-1:0] wide;
    int unsigned    t0, ts;
    bit             ok;
    for (int k = 0; k < 5; k++) begin
      pp = rand256() >> $urandom_range(0, 200);
      if (k == 0) pp[W-1] = 1'b1;
      if (pp < W'(2)) pp = W'(3);
      wide = {rand256(), rand256()};
      xx = W'(wide % (2*W)'(pp));
      ee = rand256() >> $urandom_range(0, 255);
      want = model_pow(xx, ee, pp);
      send(xx, ee, pp, t0);
      wait_valid(r, ts, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL rand%0d_timeout: no o_valid within %0d cycles", k, WAIT_MAX);
      end else begin
        if (r !== want) begin n_fail++; $display("FAIL rand%0d_res: got %h want %h", k, r, want); end
        n_tests++;
        if (ts - t0 != exp_lat(ee)) begin
          n_fail++; $display("FAIL rand%0d_lat: got %0d want %0d", k, ts - t0, exp_lat(ee));
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
